// File: rtl/add_share_pkg.sv
// Shared types and widths for the add_share_arb adder-sharing block.
package add_share_pkg;

  localparam int ADD_W = 32;  // width of one adder beat
  localparam int OP_W  = 64;  // width of a full (wide) operand

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/csla_bec32.sv
// 32-bit carry-select adder using binary-to-excess-1 converters.
// The first 4-bit block ripples with the real carry-in. Every later block
// computes its sum assuming carry-in 0 and derives the carry-in 1 result
// with a BEC (increment) instead of a second ripple adder; the incoming
// block carry selects between the two.
module csla_bec32
  import add_share_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout
);

  localparam int BLK  = 4;
  localparam int NBLK = ADD_W / BLK;

  // carry into each block; c[NBLK] is the final carry-out
  logic [NBLK:0] c;

  assign c[0] = cin;
  assign cout = c[NBLK];

  genvar gi;
  generate
    for (gi = 0; gi < NBLK; gi++) begin : g_blk
      if (gi == 0) begin : g_first
        assign {c[1], sum[BLK-1:0]} = {1'b0, a[BLK-1:0]} + {1'b0, b[BLK-1:0]} + {4'b0000, c[0]};
      end else begin : g_sel
        logic [BLK:0] r0;   // block result for carry-in 0
        logic [BLK:0] r1;   // block result for carry-in 1 (BEC of r0)
        assign r0    = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]};
        assign r1[0] = ~r0[0];
        assign r1[1] = r0[1] ^ r0[0];
        assign r1[2] = r0[2] ^ (&r0[1:0]);
        assign r1[3] = r0[3] ^ (&r0[2:0]);
        assign r1[4] = r0[4] ^ (&r0[3:0]);
        assign {c[gi+1], sum[gi*BLK +: BLK]} = c[gi] ? r1 : r0;
      end
    end
  endgenerate

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: round-robin sharing of one csla_bec32 adder among NREQ
// requesters. A 64-bit op runs as two 32-bit beats with carry chained
// through a register; one op in flight; result on a valid/ready channel.
// Optional build macro ADD_SUB_EN adds a per-requester req_sub port that
// turns the op into a - b (b inverted on both beats, low-beat carry-in 1).
module add_share_arb
  import add_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [NREQ-1:0]      req_cin,
`ifdef ADD_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [OP_W-1:0]      rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  state_t            state_reg, state_next;
  logic [IW-1:0]     ptr_reg;
  logic [IW-1:0]     id_reg;
  logic              wide_reg;
  logic              cin_reg;
  logic              carry_reg;
  logic              cout_reg;
  logic [OP_W-1:0]   a_reg;
  logic [OP_W-1:0]   b_reg;
  logic [ADD_W-1:0]  sum_lo_reg;
  logic [ADD_W-1:0]  sum_hi_reg;
`ifdef ADD_SUB_EN
  logic              sub_reg;
`endif

  logic [IW:0]       pick;
  logic              pick_found;
  logic [IW-1:0]     pick_id;
  logic              accept;

  logic [ADD_W-1:0]  add_a;
  logic [ADD_W-1:0]  add_b;
  logic              add_cin;
  logic [ADD_W-1:0]  add_sum;
  logic              add_cout;

  // Round-robin search starting at ptr and wrapping; returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                          input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] win;
    int            idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    return {found, win};
  endfunction

  // Arbitration winner for the current ptr
  always_comb begin
    pick       = rr_pick(req_valid, ptr_reg);
    pick_found = pick[IW];
    pick_id    = pick[IW-1:0];
  end

  assign accept = (state_reg == IDLE) && pick_found;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and the one-hot accept strobe
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          req_ready[pick_id] = 1'b1;
          state_next         = LO;
        end
      end
      LO:      state_next = wide_reg ? HI : RESP;
      HI:      state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Feed the shared adder with the latched half selected by the beat
  always_comb begin
    add_a   = (state_reg == HI) ? a_reg[OP_W-1:ADD_W] : a_reg[ADD_W-1:0];
    add_b   = (state_reg == HI) ? b_reg[OP_W-1:ADD_W] : b_reg[ADD_W-1:0];
    add_cin = (state_reg == HI) ? carry_reg : cin_reg;
`ifdef ADD_SUB_EN
    if (sub_reg) add_b = ~add_b;
`endif
  end

  csla_bec32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Operand capture, per-beat result registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg    <= '0;
      id_reg     <= '0;
      wide_reg   <= 1'b0;
      cin_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_lo_reg <= '0;
      sum_hi_reg <= '0;
`ifdef ADD_SUB_EN
      sub_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            id_reg   <= pick_id;
            wide_reg <= req_wide[pick_id];
            a_reg    <= req_a[pick_id*OP_W +: OP_W];
            b_reg    <= req_b[pick_id*OP_W +: OP_W];
`ifdef ADD_SUB_EN
            // subtraction is a + ~b + 1, so the requester's carry-in is ignored
            sub_reg  <= req_sub[pick_id];
            cin_reg  <= req_sub[pick_id] | req_cin[pick_id];
`else
            cin_reg  <= req_cin[pick_id];
`endif
          end
        end
        LO: begin
          sum_lo_reg <= add_sum;
          carry_reg  <= add_cout;
          if (!wide_reg) begin
            cout_reg   <= add_cout;
            sum_hi_reg <= '0;
          end
        end
        HI: begin
          sum_hi_reg <= add_sum;
          cout_reg   <= add_cout;
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_reg <= (id_reg == IW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign rsp_id    = id_reg;
  assign rsp_sum   = {sum_hi_reg, sum_lo_reg};
  assign rsp_cout  = cout_reg;

endmodule
